// File: rtl/sample_sched_pkg.sv
// Shared types and defaults for the sample scheduler.
// Channel buses are flattened; slice_lo() gives the low bit of a channel's slice.
package sample_sched_pkg;

    localparam int NUM_CH_DEF   = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int PERIOD_W_DEF = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/sample_scheduler_if.sv
// Valid/ready sample stream from the scheduler to the trace/capture sink.
// The scheduler drives the master modport and the sink drives the slave modport.
interface sample_scheduler_if #(
    parameter int DATA_W = 8,
    parameter int CH_W   = 2
);
    logic              smp_valid;
    logic              smp_ready;
    logic [DATA_W-1:0] smp_data;
    logic [CH_W-1:0]   smp_ch;

    modport master (
        output smp_valid,
        output smp_data,
        output smp_ch,
        input  smp_ready
    );

    modport slave (
        input  smp_valid,
        input  smp_data,
        input  smp_ch,
        output smp_ready
    );
endinterface

// File: rtl/sample_scheduler_rr_arbiter.sv
// Round-robin pick of one requester, scanning upward from ptr+1 with wrap.
// Latency: purely combinational.
// Backpressure: en low suppresses every grant.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    always_comb begin
        int              cand;
        logic [CH_W-1:0] c;
        cand    = 0;
        c       = '0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // The current holder of ptr is scanned last, so it only wins when alone.
        for (int off = 1; off <= NUM_CH; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            c = CH_W'(cand);
            if (!gnt_any && en && req[c]) begin
                gnt_any = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = c;
            end
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Freezes per-channel samples on strobe or timer trigger and serialises them round-robin.
// Latency: trigger at edge k, ch_ack during k..k+1, smp_valid after edge k+1.
// Backpressure: output register holds while smp_ready is low; repeat triggers set ovf.
module sample_scheduler
    import sample_sched_pkg::*;
#(
    parameter  int NUM_CH   = NUM_CH_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int PERIOD_W = PERIOD_W_DEF,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_en,
    input  logic [NUM_CH*PERIOD_W-1:0] cfg_period,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic [NUM_CH-1:0]          ovf,
    input  logic [NUM_CH-1:0]          ovf_clr,
    sample_scheduler_if.master         smp
);

    logic [NUM_CH-1:0]        trig;
    logic [NUM_CH-1:0]        pend_q;
    logic [NUM_CH-1:0]        ovf_q;
    logic [NUM_CH*DATA_W-1:0] hold_flat;

    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              gnt_en;
    logic [CH_W-1:0]   rr_ptr_q;

    out_state_e        state_q;
    out_state_e        state_d;
    logic [DATA_W-1:0] smp_data_q;
    logic [CH_W-1:0]   smp_ch_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [PERIOD_W-1:0] per;
        logic [PERIOD_W-1:0] cnt_q;
        logic [DATA_W-1:0]   hold_q;
        logic                tmr_exp;

        assign per     = cfg_period[slice_lo(i, PERIOD_W) +: PERIOD_W];
        assign tmr_exp = cfg_en && (per != '0) && (cnt_q == per - PERIOD_W'(1));
        assign trig[i] = ch_req[i] | tmr_exp;

        // A counter left beyond a freshly shortened period restarts silently.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (!cfg_en || (per == '0) || (cnt_q >= per) || tmr_exp) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + PERIOD_W'(1);
            end
        end

        // An overrun keeps the older sample; a same-cycle grant frees the slot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= '0;
            end else if (trig[i] && (!pend_q[i] || gnt[i])) begin
                hold_q <= ch_data[slice_lo(i, DATA_W) +: DATA_W];
            end
        end

        assign hold_flat[slice_lo(i, DATA_W) +: DATA_W] = hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= trig | (pend_q & ~gnt);
            ovf_q  <= (ovf_q & ~ovf_clr) | (trig & pend_q & ~gnt);
        end
    end

    assign gnt_en = (state_q == OUT_EMPTY) || smp.smp_ready;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req     (pend_q),
        .ptr     (rr_ptr_q),
        .en      (gnt_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OUT_EMPTY: if (gnt_any) state_d = OUT_FULL;
            OUT_FULL:  if (smp.smp_ready && !gnt_any) state_d = OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_data_q <= '0;
            smp_ch_q   <= '0;
            rr_ptr_q   <= CH_W'(NUM_CH - 1);
        end else if (gnt_any) begin
            smp_data_q <= hold_flat[slice_lo(int'(gnt_idx), DATA_W) +: DATA_W];
            smp_ch_q   <= gnt_idx;
            rr_ptr_q   <= gnt_idx;
        end
    end

    assign smp.smp_valid = (state_q == OUT_FULL);
    assign smp.smp_data  = smp_data_q;
    assign smp.smp_ch    = smp_ch_q;
    assign ch_ack        = gnt;
    assign ovf           = ovf_q;

endmodule

// File: doc/sample_scheduler.md
# sample_scheduler

Shared-capture scheduler for sampled-value probes: up to NUM_CH channels request a snapshot of their data, either by strobe or from a per-channel period timer. Each channel's value is frozen at its request edge, and a round-robin arbiter serialises the frozen values into one valid/ready output stream. It sits between the `$sampled`-style probe points and the single trace/capture sink that records them.

## Interface
- NUM_CH, 4: number of requesting channels (2..16)
- DATA_W, 8: width of each channel's data
- PERIOD_W, 8: width of each channel's period configuration
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- cfg_en  in  1  enables period timers; when low, counters are held at 0
- cfg_period  in  NUM_CH*PERIOD_W  per-channel period in cycles, channel i at [i*PERIOD_W +: PERIOD_W]; 0 = timer disabled
- ch_req  in  NUM_CH  one-cycle sample strobe per channel
- ch_data  in  NUM_CH*DATA_W  live channel values, channel i at [i*DATA_W +: DATA_W]
- ch_ack  out  NUM_CH  one-cycle pulse: channel's held sample was moved to the output register
- ovf  out  NUM_CH  sticky per-channel overrun flag
- ovf_clr  in  NUM_CH  clears the matching ovf bits
- smp_valid  out  1  output holds a sample
- smp_ready  in  1  sink accepts the sample
- smp_data  out  DATA_W  sampled value
- smp_ch  out  $clog2(NUM_CH)  source channel of smp_data

## Operation
- Trigger for channel i in a cycle = ch_req[i], OR the timer for i expires. Timer expiry: cfg_en=1, cfg_period[i]≠0, and cnt[i]==cfg_period[i]-1. The counter then wraps to 0.
- When the period changes, a counter already ≥ the new period wraps to 0 on the next edge without triggering.
- Trigger while channel not pending, or while it is granted in the same cycle:
  - pend[i] set.
  - hold[i] ← ch_data[i] at that edge.
- Trigger while pending and not granted that cycle:
  - hold[i] keeps the older value.
  - ovf[i] set.
  - If ovf_clr[i] and set coincide, set wins.
- Output register FSM, states EMPTY and FULL:
  - EMPTY → FULL on a grant.
  - FULL → FULL when smp_ready is high and there is a new grant; the sink drains and reloads in one cycle.
  - FULL → EMPTY when smp_ready is high and there is no grant.
  - FULL holds with data stable while smp_ready is low.
- Grant allowed when the FSM is EMPTY or (FULL and smp_ready).
- On a grant:
  - The winner is the first pending channel scanning upward from rr_ptr+1, wrapping.
  - smp_data ← hold[w], smp_ch ← w.
  - pend[w] cleared, unless retriggered the same cycle.
  - ch_ack[w] pulses.
  - rr_ptr ← w.
- smp_data and smp_ch are stable while smp_valid=1 and smp_ready=0.

## Timing
- Reset values (async):
  - smp_valid=0, smp_data=0, smp_ch=0.
  - ch_ack=0, ovf=0.
  - All pend=0 and hold=0; counters=0.
  - rr_ptr=NUM_CH-1, so channel 0 wins first.
- Reset mid-operation drops all pending samples and the output sample; no ack is issued.
- Latency:
  - A strobe sampled at edge k sets pend at k.
  - smp_valid=1 after edge k+1 if the output is free.
  - ch_ack[i] is high in the cycle between edges k and k+1.
- Throughput: one sample per cycle while smp_ready=1.
- Timer timing: first expiry cfg_period cycles after cfg_en rises, then every cfg_period cycles. Period 1 = trigger every cycle.
- All outputs are registered except ch_ack, which is combinational from pend, rr_ptr, FSM state and smp_ready.

## Structure
- Package sample_sched_pkg holds:
  - typedef enum {OUT_EMPTY, OUT_FULL} out_state_e.
  - The default NUM_CH, DATA_W and PERIOD_W localparams.
  - A function that decodes the flattened channel slice.
- Sub-module rr_arbiter (NUM_CH): inputs req vector, ptr and en; outputs one-hot gnt, grant index and any-grant flag. It is purely combinational.
- Top level holds the per-channel counters, pend/hold/ovf arrays, the output register and the FSM.

## Test plan
- Single strobe: ch_req[2] with ch_data[2]=8'hA5, smp_ready=1 → smp_valid=1, smp_ch=2, smp_data=8'hA5 one cycle later; ch_ack[2] pulses once.
- Frozen value: ch_req[1] while ch_data[1]=8'h11, ch_data[1] changes to 8'h22 next cycle, smp_ready=0 for 5 cycles → smp_data=8'h11 throughout and on acceptance.
- Round robin: all four channels strobed together, smp_ready=1 → smp_ch sequence 0,1,2,3 on consecutive cycles. A second burst gives 0,1,2,3 again, since rr_ptr=3.
- Overrun: ch_req[0] twice, 8'h01 then 8'h02, while smp_ready=0 and the output is FULL → ovf[0]=1 and the delivered value is 8'h01. ovf_clr[0] → ovf[0]=0 next cycle.
- Timer: cfg_period[3]=3, cfg_en rises → channel-3 samples every 3 cycles with smp_ready=1; cfg_period=0 stops them.
- Reset mid-flight: rst_n low while FULL with 2 channels pending → all outputs are 0 immediately. After release there is no smp_valid until a new trigger.
